// File: rtl/oddr_bank.sv
// oddr_bank: multi-bit DDR output register bank with per-bit data inversion,
// per-bit reset value, three DDR clock-edge modes, clock enable, stretched
// synchronous reset and a registered tristate control.
module oddr_bank #(
  parameter int               WIDTH          = 1,
  parameter string            DDR_CLK_EDGE   = "SAME_EDGE",
  parameter int               SR_STRETCH     = 3,
  parameter logic [WIDTH-1:0] SRVAL          = '0,
  parameter logic             TSRVAL         = 1'b1,
  parameter logic             IS_C_INVERTED  = 1'b0,
  parameter logic [WIDTH-1:0] IS_D1_INVERTED = '0,
  parameter logic [WIDTH-1:0] IS_D2_INVERTED = '0
) (
  input  logic             C,
  input  logic             SR,
  input  logic             CE,
  input  logic [WIDTH-1:0] D1,
  input  logic [WIDTH-1:0] D2,
  input  logic             T,
  output logic [WIDTH-1:0] Q,
  output logic             TQ
);

  localparam bit MODE_OPP  = (DDR_CLK_EDGE == "OPPOSITE_EDGE");
  localparam bit MODE_SE   = (DDR_CLK_EDGE == "SAME_EDGE");
  localparam bit MODE_PIPE = (DDR_CLK_EDGE == "SAME_EDGE_PIPELINED");
  // History depth follows the stretch so the full 0..7 range is covered;
  // one dummy bit is kept when no stretch is requested.
  localparam int HW        = (SR_STRETCH > 0) ? SR_STRETCH : 1;

  if (!(MODE_OPP || MODE_SE || MODE_PIPE)) begin : g_bad_mode
    $error("oddr_bank: DDR_CLK_EDGE must be OPPOSITE_EDGE, SAME_EDGE or SAME_EDGE_PIPELINED");
  end
  if (SR_STRETCH < 0 || SR_STRETCH > 7) begin : g_bad_stretch
    $error("oddr_bank: SR_STRETCH out of range 0..7");
  end
  if (WIDTH < 1 || WIDTH > 64) begin : g_bad_width
    $error("oddr_bank: WIDTH out of range 1..64");
  end

  logic             w_C;
  logic [WIDTH-1:0] w_d1, w_d2;
  logic [HW-1:0]    r_hist, w_hist_nxt;
  logic             w_rst;
  logic             r_rst;   // rst as seen at the last posedge, used by the negedge path
  logic [WIDTH-1:0] r_qp;    // value driven in the high phase
  logic [WIDTH-1:0] r_qn;    // value driven in the low phase
  logic             r_tq;

  assign w_C  = C ^ IS_C_INVERTED;
  assign w_d1 = D1 ^ IS_D1_INVERTED;
  assign w_d2 = D2 ^ IS_D2_INVERTED;

  // SR history shift: bit k holds SR from k+1 posedges ago
  always_comb begin
    w_hist_nxt    = r_hist;
    w_hist_nxt[0] = SR;
    for (int i = 1; i < HW; i++) w_hist_nxt[i] = r_hist[i-1];
  end

  assign w_rst = SR | ((SR_STRETCH > 0) && (|r_hist));

  // Reset history and registered reset for the negedge path
  always_ff @(posedge w_C) begin
    r_hist <= w_hist_nxt;
    r_rst  <= w_rst;
  end

  if (MODE_OPP) begin : g_opp
    logic r_ce;  // CE sampled at posedge n gates D2 capture at negedge n

    // High-phase data and tristate capture
    always_ff @(posedge w_C) begin
      r_ce <= CE;
      if (w_rst) begin
        r_qp <= SRVAL;
        r_tq <= TSRVAL;
      end else if (CE) begin
        r_qp <= w_d1;
        r_tq <= T;
      end
    end

    // Low-phase data captured straight from D2 on the falling edge
    always_ff @(negedge w_C) begin
      if (r_rst)     r_qn <= SRVAL;
      else if (r_ce) r_qn <= w_d2;
    end
  end else if (MODE_SE) begin : g_se
    logic [WIDTH-1:0] r_ql;  // D2 held from posedge until the low phase

    // Both data words and tristate captured on the rising edge
    always_ff @(posedge w_C) begin
      if (w_rst) begin
        r_qp <= SRVAL;
        r_ql <= SRVAL;
        r_tq <= TSRVAL;
      end else if (CE) begin
        r_qp <= w_d1;
        r_ql <= w_d2;
        r_tq <= T;
      end
    end

    // Transfer held D2 to the low-phase output register
    always_ff @(negedge w_C) begin
      if (r_rst) r_qn <= SRVAL;
      else       r_qn <= r_ql;
    end
  end else if (MODE_PIPE) begin : g_pipe
    logic [WIDTH-1:0] r_s1, r_s2, r_ql;
    logic             r_st;

    // Input stage holds on CE low, output stage always advances so the
    // last captured pair repeats; reset clears both stages (pipe flush)
    always_ff @(posedge w_C) begin
      if (w_rst) begin
        r_s1 <= SRVAL;
        r_s2 <= SRVAL;
        r_st <= TSRVAL;
        r_qp <= SRVAL;
        r_ql <= SRVAL;
        r_tq <= TSRVAL;
      end else begin
        if (CE) begin
          r_s1 <= w_d1;
          r_s2 <= w_d2;
          r_st <= T;
        end
        r_qp <= r_s1;
        r_ql <= r_s2;
        r_tq <= r_st;
      end
    end

    // Transfer pipelined D2 to the low-phase output register
    always_ff @(negedge w_C) begin
      if (r_rst) r_qn <= SRVAL;
      else       r_qn <= r_ql;
    end
  end

  assign Q  = w_C ? r_qp : r_qn;
  assign TQ = r_tq;

endmodule
